fn_logic_seq: RTL and testbench
===============================

FN_LOGIC_SEQ -- requirements
Module: fn_logic_seq

Interface
REQ-001 The block SHALL take parameter SLICE_W, default 8, which sets the operand bits processed per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand request presented by the initiator.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
REQ-009 out_valid  output  1  result Y is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 Y  output  32  result.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-014 A request SHALL be accepted on an edge where state=IDLE and in_valid=1; a, b and op are captured and the FSM moves to BUSY with slice counter=0.
REQ-015 In BUSY, each cycle SHALL compute slice k (bits k*SLICE_W .. k*SLICE_W+SLICE_W-1, LSB slice first) from the captured operands and store it in an internal accumulator, then increment k.
REQ-016 After N=32/SLICE_W BUSY cycles, the FSM SHALL move to DONE and load Y from the completed accumulator; latency from the accept edge to out_valid=1 is therefore N+0 edges (4 with the default).
REQ-017 Y SHALL change only when DONE is entered, so partial results are never visible; Y holds its last result in every other state.
REQ-018 In DONE, out_valid and Y SHALL stay stable until out_ready=1; on that edge the FSM returns to IDLE.
REQ-019 Changes on a, b, op or in_valid during BUSY or DONE SHALL be ignored; there is no overlap between requests.
REQ-020 For SLICE_W=32, BUSY SHALL last exactly one cycle.
REQ-021 After DONE->IDLE, a new request with in_valid already high SHALL be accepted on the next edge (one idle cycle minimum between results).

Reset
REQ-022 When rst_n=0 at an edge, the block SHALL go to IDLE and clear Y, the accumulator, the captured operands and the counter to 0; the result is out_valid=0 and in_ready=1 after that edge.
REQ-023 A reset during BUSY or DONE SHALL discard the operation in progress without producing a result.

Configuration
REQ-024 With macro FN_LOGIC_SEQ_ZERO_FLAG_EN defined, the block SHALL add a 1-bit output, zero, placed after Y. zero is registered together with Y, equals (result == 0), and resets to 0.
REQ-025 Without FN_LOGIC_SEQ_ZERO_FLAG_EN, the zero port and its logic SHALL not exist, and all other behaviour is identical.

Verification
REQ-026 The bench SHALL cover reset, then a=FFFF0000, b=0F0F0F0F, op=00 accepted with out_ready=1 -> out_valid high 4 edges later, Y=0F0F0000, then back to IDLE.
REQ-027 The bench SHALL cover the operation sweep over the 4 combinations a={32{i[0]}}, b={32{i[1]}} for op=00..11 -> Y matches the AND/OR/XOR/ANDN truth table (all-0 or all-1 words).
REQ-028 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE, with a and b toggled and in_valid=1 -> Y and out_valid stable, in_ready=0, and no second accept.
REQ-029 The bench SHALL cover reset mid-operation: rst_n=0 on the 2nd BUSY cycle of a=12345678, b=FFFFFFFF, op=01 -> out_valid never rises, Y=0, in_ready=1 next cycle.
REQ-030 The bench SHALL cover SLICE_W=1 and SLICE_W=32 with a=A5A5A5A5, b=5A5A5A5A, op=10 -> Y=FFFFFFFF after latency 32 and 1 respectively.
REQ-031 With FN_LOGIC_SEQ_ZERO_FLAG_EN defined, the bench SHALL cover a=F0F0F0F0, b=0F0F0F0F, op=00 -> Y=00000000 and zero=1; then op=01 -> zero=0.

Source files
------------

// File: rtl/fn_logic_seq.sv
// fn_logic_seq: bit-sliced AND/OR/XOR/ANDN unit, SLICE_W operand bits per BUSY cycle.
// Optional registered `zero` result flag when FN_LOGIC_SEQ_ZERO_FLAG_EN is defined.
module fn_logic_seq #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Y
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  localparam int N = 32 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [1:0]         op_q;
  logic [31:0]        acc;
  logic [31:0]        acc_next;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] r_sl;
  logic               last;

  assign a_sl = a_q[int'(cnt) * SLICE_W +: SLICE_W];
  assign b_sl = b_q[int'(cnt) * SLICE_W +: SLICE_W];
  assign last = (cnt == LAST);

  always_comb begin
    r_sl = '0;
    case (op_q)
      2'b00:   r_sl = a_sl & b_sl;
      2'b01:   r_sl = a_sl | b_sl;
      2'b10:   r_sl = a_sl ^ b_sl;
      default: r_sl = a_sl & ~b_sl;
    endcase
  end

  // The accumulator is cleared on accept, so OR-ing each slice into place is enough.
  assign acc_next = acc | (32'(r_sl) << (int'(cnt) * SLICE_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Y (and zero) load only on the BUSY->DONE edge so partial results never leak out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      acc  <= '0;
      cnt  <= '0;
      Y    <= '0;
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
      zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            Y <= acc_next;
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
            zero <= (acc_next == 32'd0);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fn_logic_seq.sv
// Scoreboard bench for fn_logic_seq: three instances (SLICE_W 8, 1, 32); expected results
// are queued at issue and popped by a monitor on each out_valid/out_ready handshake.
module tb_fn_logic_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [31:0] y         [3];
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
  logic        zero      [3];
`endif

  int errors = 0;
  int checks = 0;

  // Queue entries are {expected zero flag, expected Y}.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  always #5 clk = ~clk;

  fn_logic_seq #(.SLICE_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .Y(y[0])
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero[0])
`endif
  );

  fn_logic_seq #(.SLICE_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .Y(y[1])
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero[1])
`endif
  );

  fn_logic_seq #(.SLICE_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .Y(y[2])
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
    , .zero(zero[2])
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int idx, input logic [31:0] ey);
    case (idx)
      0:       q0.push_back({ey == 32'd0, ey});
      1:       q1.push_back({ey == 32'd0, ey});
      default: q2.push_back({ey == 32'd0, ey});
    endcase
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [32:0] q_pop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: a result is consumed on the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i] && out_ready[i]) begin
        if (q_size(i) == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result dut%0d: got Y=%h, expected no result", i, y[i]);
        end else begin
          e = q_pop(i);
          checkOutput($sformatf("result_y dut%0d", i), y[i], e[31:0]);
`ifdef FN_LOGIC_SEQ_ZERO_FLAG_EN
          checkOutput($sformatf("result_zero dut%0d", i), 32'(zero[i]), 32'(e[32]));
`endif
        end
      end
    end
  end

  // Issue one request to instance idx, check accept-to-valid latency and return to IDLE.
  task automatic applyStimulus(input int idx, input logic [31:0] av, input logic [31:0] bv,
                               input logic [1:0] opv, input logic [31:0] ey, input int lat_exp);
    int n;
    push_exp(idx, ey);
    a = av;
    b = bv;
    op = opv;
    out_ready[idx] = 1'b1;
    in_valid[idx] = 1'b1;
    n = 0;
    while (!in_ready[idx] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    n = 0;
    while (!out_valid[idx] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("latency dut%0d", idx), 32'(n), 32'(lat_exp));
    @(posedge clk); #1;
    checkOutput($sformatf("back_to_idle dut%0d", idx), 32'(in_ready[idx]), 32'd1);
  endtask

  task automatic backpressure();
    int n;
    push_exp(0, 32'h00FF_FF00);
    a = 32'h0000_FFFF;
    b = 32'h00FF_00FF;
    op = 2'b10;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_latency", 32'(n), 32'd4);
    for (int c = 0; c < 5; c++) begin
      a = ~a;
      b = ~b;
      op = op + 2'd1;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid[0]), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready[0]), 32'd0);
      checkOutput("bp_y_stable", y[0], 32'h00FF_FF00);
    end
    a = 32'hF0F0_F0F0;
    b = 32'hFF00_FF00;
    op = 2'b11;
    push_exp(0, 32'h00F0_00F0);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_idle_after_done", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_reaccept", 32'(in_ready[0]), 32'd0);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_latency2", 32'(n), 32'd4);
    @(posedge clk); #1;
    checkOutput("bp_idle_final", 32'(in_ready[0]), 32'd1);
  endtask

  task automatic resetMidOp();
    int seen;
    a = 32'h1234_5678;
    b = 32'hFFFF_FFFF;
    op = 2'b01;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checkOutput("rst_busy", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("rst_y", y[0], 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1;
    end
    checkOutput("rst_no_result", 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  tt [4];
    logic [3:0]  row;
    logic [1:0]  opv;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] ey;

    // Result bit for combination i (a=i[0], b=i[1]) per op: AND, OR, XOR, ANDN.
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0110;
    tt[3] = 4'b0010;

    rst_n = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("reset_y", y[0], 32'd0);
    checkOutput("reset_y_w1", y[1], 32'd0);
    checkOutput("reset_y_w32", y[2], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00, 32'h0F0F_0000, 4);

    for (int o = 0; o < 4; o++) begin
      row = tt[o];
      opv = 2'(o);
      for (int i = 0; i < 4; i++) begin
        av = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
        bv = (i / 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
        ey = row[i] ? 32'hFFFF_FFFF : 32'h0;
        applyStimulus(0, av, bv, opv, ey, 4);
      end
    end

    backpressure();
    resetMidOp();

    applyStimulus(1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b10, 32'hFFFF_FFFF, 32);
    applyStimulus(2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b10, 32'hFFFF_FFFF, 1);

    applyStimulus(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00, 32'h0000_0000, 4);
    applyStimulus(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b01, 32'hFFFF_FFFF, 4);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("queue_drained dut%0d", i), 32'(q_size(i)), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
